// File: rtl/ros2rapper_tx_pkg.sv
// Shared definitions for the ROS2 transmit scheduler: kind codes, FSM encoding, helpers.
// Optional round-robin arbitration is enabled by defining ROS2_TX_SCHED_RR_EN.
package ros2rapper_tx_pkg;

    localparam int NUM_KINDS = 8;
    localparam int KIND_W    = 3;

    typedef enum logic [KIND_W-1:0] {
        KIND_SPDP_WR     = 3'd0,
        KIND_SEDP_PUB_WR = 3'd1,
        KIND_SEDP_SUB_WR = 3'd2,
        KIND_SEDP_PUB_HB = 3'd3,
        KIND_SEDP_SUB_HB = 3'd4,
        KIND_SEDP_PUB_AN = 3'd5,
        KIND_SEDP_SUB_AN = 3'd6,
        KIND_APP_WR      = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    function automatic logic [NUM_KINDS-1:0] kind_onehot(input logic [KIND_W-1:0] kind);
        logic [NUM_KINDS-1:0] oh;
        oh       = '0;
        oh[kind] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ros2rapper_tx_arbiter.sv
// Picks one pending packet kind. Fixed priority (lowest index wins) by default;
// with ROS2_TX_SCHED_RR_EN the search starts after the last granted kind.
module ros2rapper_tx_arbiter
    import ros2rapper_tx_pkg::*;
(
`ifdef ROS2_TX_SCHED_RR_EN
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
`endif
    input  logic [NUM_KINDS-1:0] i_req,
    output logic                 o_valid,
    output logic [KIND_W-1:0]    o_kind
);

    assign o_valid = |i_req;

`ifdef ROS2_TX_SCHED_RR_EN
    logic [KIND_W-1:0] ptr_q;
    logic [KIND_W-1:0] ptr_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= 3'd7;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_d = (i_load && o_valid) ? o_kind : ptr_q;

    // Offset 8 wraps to the pointer itself, so the last-granted kind is tried last.
    always_comb begin
        logic              found;
        logic [KIND_W-1:0] idx;
        found  = 1'b0;
        idx    = '0;
        o_kind = '0;
        for (int i = 1; i <= NUM_KINDS; i++) begin
            idx = ptr_q + KIND_W'(i);
            if (!found && i_req[idx]) begin
                o_kind = idx;
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        o_kind = '0;
        for (int k = NUM_KINDS - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_kind = KIND_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/ros2rapper_tx_scheduler.sv
// Transmit scheduler: grants elapsed+enabled packet kinds to the packet generator,
// waits for completion (or timeout) and reloads the matching period counters.
// Arbitration mode is selected by ROS2_TX_SCHED_RR_EN (round-robin when defined).
module ros2rapper_tx_scheduler
    import ros2rapper_tx_pkg::*;
#(
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_interval_elapsed,
    input  logic [NUM_KINDS-1:0] i_kind_elapsed,
    input  logic [NUM_KINDS-1:0] i_kind_enable,
    output logic [NUM_KINDS-1:0] o_cnt_set,
    output logic                 o_cnt_interval_set,
    output logic                 o_tx_start,
    output logic [KIND_W-1:0]    o_tx_kind,
    input  logic                 i_tx_ready,
    input  logic                 i_tx_done,
    output logic                 o_busy,
    output logic                 o_timeout,
    output state_e               o_fsm_state
);

    localparam int CNT_W = $clog2(DONE_TIMEOUT);

    // Handshake: o_tx_start is held with a stable o_tx_kind until the first cycle
    // i_tx_ready is high; that cycle transfers the request. i_tx_done only counts in WAIT_DONE.

    state_e              state_q, state_d;
    logic [KIND_W-1:0]   kind_q, kind_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KINDS-1:0] req;
    logic                gnt_valid;
    logic [KIND_W-1:0]   gnt_kind;
    logic                grant_fire;
    logic                cnt_last;
    logic                finish;

    assign req        = i_kind_elapsed & i_kind_enable;
    assign grant_fire = (state_q == ST_IDLE) && i_interval_elapsed && gnt_valid;
    assign cnt_last   = (cnt_q == CNT_W'(DONE_TIMEOUT - 1));
    assign finish     = (state_q == ST_WAIT_DONE) && (i_tx_done || cnt_last);

    ros2rapper_tx_arbiter u_arbiter (
`ifdef ROS2_TX_SCHED_RR_EN
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (grant_fire),
`endif
        .i_req   (req),
        .o_valid (gnt_valid),
        .o_kind  (gnt_kind)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            kind_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_fire) begin
                    state_d = ST_REQ;
                    kind_d  = gnt_kind;
                end
            end
            ST_REQ: begin
                if (i_tx_ready) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_DONE: begin
                if (finish) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A done arriving on the timeout cycle wins, so no abort is reported then.
    always_comb begin
        o_tx_start         = (state_q == ST_REQ);
        o_tx_kind          = kind_q;
        o_busy             = (state_q != ST_IDLE);
        o_cnt_set          = finish ? kind_onehot(kind_q) : '0;
        o_cnt_interval_set = finish;
        o_timeout          = (state_q == ST_WAIT_DONE) && cnt_last && !i_tx_done;
        o_fsm_state        = state_q;
    end

endmodule

// File: tb/tb_ros2rapper_tx_scheduler.sv
// Directed self-checking bench for the transmit scheduler (DONE_TIMEOUT = 16).
module tb_ros2rapper_tx_scheduler;
    import ros2rapper_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       interval;
    logic [7:0] elapsed;
    logic [7:0] enable;
    logic       ready;
    logic       done;
    logic [7:0] o_cnt_set;
    logic       o_cnt_interval_set;
    logic       o_tx_start;
    logic [2:0] o_tx_kind;
    logic       o_busy;
    logic       o_timeout;
    state_e     fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    ros2rapper_tx_scheduler #(.DONE_TIMEOUT(16)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_interval_elapsed (interval),
        .i_kind_elapsed     (elapsed),
        .i_kind_enable      (enable),
        .o_cnt_set          (o_cnt_set),
        .o_cnt_interval_set (o_cnt_interval_set),
        .o_tx_start         (o_tx_start),
        .o_tx_kind          (o_tx_kind),
        .i_tx_ready         (ready),
        .i_tx_done          (done),
        .o_busy             (o_busy),
        .o_timeout          (o_timeout),
        .o_fsm_state        (fsm_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        interval = 1'b0;
        elapsed  = 8'h00;
        enable   = 8'h00;
        ready    = 1'b0;
        done     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_start(output logic ok, output logic [2:0] kind);
        ok   = 1'b0;
        kind = 3'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_tx_start === 1'b1) begin
                ok   = 1'b1;
                kind = o_tx_kind;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        interval = 1'b1;
        elapsed  = 8'hFF;
        enable   = 8'hFF;
        ready    = 1'b1;
        done     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (o_tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b want 0", o_tx_start); end
        n_cmp++; if (o_tx_kind !== 3'd0) begin n_err++; $display("FAIL reset_tx_kind: got %0d want 0", o_tx_kind); end
        n_cmp++; if (o_cnt_set !== 8'h00) begin n_err++; $display("FAIL reset_cnt_set: got %h want 00", o_cnt_set); end
        n_cmp++; if (o_cnt_interval_set !== 1'b0) begin n_err++; $display("FAIL reset_interval_set: got %b want 0", o_cnt_interval_set); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", o_timeout); end
    endtask

    task automatic test_basic();
        apply_reset();
        interval = 1'b1;
        elapsed  = 8'h81;
        enable   = 8'hFF;
        ready    = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_tx_start !== 1'b0) begin n_err++; $display("FAIL basic_idle_start: got %b want 0", o_tx_start); end
        tick();
        interval = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_tx_start !== 1'b1) begin n_err++; $display("FAIL basic_start: got %b want 1", o_tx_start); end
        n_cmp++; if (o_tx_kind !== 3'd0) begin n_err++; $display("FAIL basic_kind: got %0d want 0", o_tx_kind); end
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", o_busy); end
        tick();
        @(negedge clk);
        n_cmp++; if (o_tx_start !== 1'b0) begin n_err++; $display("FAIL basic_wait_start: got %b want 0", o_tx_start); end
        n_cmp++; if (o_cnt_set !== 8'h00) begin n_err++; $display("FAIL basic_wait_set: got %h want 00", o_cnt_set); end
        repeat (4) tick();
        done = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_cnt_set !== 8'h01) begin n_err++; $display("FAIL basic_done_set: got %h want 01", o_cnt_set); end
        n_cmp++; if (o_cnt_interval_set !== 1'b1) begin n_err++; $display("FAIL basic_done_interval: got %b want 1", o_cnt_interval_set); end
        n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL basic_done_timeout: got %b want 0", o_timeout); end
        tick();
        done = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_cnt_set !== 8'h00) begin n_err++; $display("FAIL basic_after_set: got %h want 00", o_cnt_set); end
        n_cmp++; if (o_cnt_interval_set !== 1'b0) begin n_err++; $display("FAIL basic_after_interval: got %b want 0", o_cnt_interval_set); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL basic_after_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_arbitration();
        logic       ok;
        logic [2:0] k;
        logic [2:0] want;
        apply_reset();
`ifdef ROS2_TX_SCHED_RR_EN
        exp_q.push_back(3'd0); exp_q.push_back(3'd7); exp_q.push_back(3'd0);
`else
        exp_q.push_back(3'd0); exp_q.push_back(3'd0); exp_q.push_back(3'd0);
`endif
        interval = 1'b1;
        elapsed  = 8'h81;
        enable   = 8'hFF;
        ready    = 1'b1;
        for (int t = 0; t < 3; t++) begin
            wait_start(ok, k);
            want = exp_q.pop_front();
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL arb_start_%0d: got %b want 1", t, ok); end
            n_cmp++; if (k !== want) begin n_err++; $display("FAIL arb_kind_%0d: got %0d want %0d", t, k, want); end
            tick();
            done = 1'b1;
            @(negedge clk);
            n_cmp++; if (o_cnt_set !== (8'h01 << want)) begin n_err++; $display("FAIL arb_set_%0d: got %h want %h", t, o_cnt_set, 8'h01 << want); end
            tick();
            done = 1'b0;
        end
        interval = 1'b0;
    endtask

    task automatic test_ready_stall();
        logic       ok;
        logic [2:0] k;
        int         bad;
        apply_reset();
        interval = 1'b1;
        elapsed  = 8'h10;
        enable   = 8'hFF;
        ready    = 1'b0;
        wait_start(ok, k);
        n_cmp++; if (ok !== 1'b1 || k !== 3'd4) begin n_err++; $display("FAIL stall_first: got ok=%b kind=%0d want ok=1 kind=4", ok, k); end
        // Withdraw the request: the scheduler must keep asking.
        interval = 1'b0;
        elapsed  = 8'h00;
        bad      = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_tx_start !== 1'b1 || o_tx_kind !== 3'd4) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stall_stable: got %0d unstable cycles want 0", bad); end
        ready = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (o_tx_start !== 1'b0 || fsm_state !== ST_WAIT_DONE) begin n_err++; $display("FAIL stall_accept: got start=%b state=%0d want start=0 state=2", o_tx_start, fsm_state); end
        tick();
        done = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_cnt_set !== 8'h10) begin n_err++; $display("FAIL stall_done_set: got %h want 10", o_cnt_set); end
        tick();
        done = 1'b0;
    endtask

    task automatic test_timeout(input logic with_done);
        logic       ok;
        logic [2:0] k;
        int         early;
        logic       want_to;
        apply_reset();
        interval = 1'b1;
        elapsed  = 8'h04;
        enable   = 8'hFF;
        ready    = 1'b1;
        wait_start(ok, k);
        interval = 1'b0;
        elapsed  = 8'h00;
        n_cmp++; if (ok !== 1'b1 || k !== 3'd2) begin n_err++; $display("FAIL to_start_%0d: got ok=%b kind=%0d want ok=1 kind=2", with_done, ok, k); end
        @(posedge clk);
        #1;
        early = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (o_timeout !== 1'b0 || o_cnt_set !== 8'h00) early++;
        end
        if (with_done) begin
            @(posedge clk);
            #1;
            done = 1'b1;
        end
        @(negedge clk);
        want_to = !with_done;
        n_cmp++; if (early != 0) begin n_err++; $display("FAIL to_early_%0d: got %0d early pulses want 0", with_done, early); end
        n_cmp++; if (o_timeout !== want_to) begin n_err++; $display("FAIL to_pulse_%0d: got %b want %b", with_done, o_timeout, want_to); end
        n_cmp++; if (o_cnt_set !== 8'h04) begin n_err++; $display("FAIL to_set_%0d: got %h want 04", with_done, o_cnt_set); end
        n_cmp++; if (o_cnt_interval_set !== 1'b1) begin n_err++; $display("FAIL to_interval_%0d: got %b want 1", with_done, o_cnt_interval_set); end
        tick();
        done = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_busy !== 1'b0 || fsm_state !== ST_IDLE || o_timeout !== 1'b0) begin n_err++; $display("FAIL to_idle_%0d: got busy=%b state=%0d to=%b want 0/0/0", with_done, o_busy, fsm_state, o_timeout); end
    endtask

    task automatic test_no_interval();
        logic       ok;
        logic [2:0] k;
        int         starts;
        int         sets;
        apply_reset();
        interval = 1'b0;
        elapsed  = 8'hFF;
        enable   = 8'hFF;
        ready    = 1'b1;
        done     = 1'b1;
        starts   = 0;
        sets     = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_tx_start !== 1'b0) starts++;
            if (o_cnt_set !== 8'h00 || o_cnt_interval_set !== 1'b0) sets++;
        end
        done = 1'b0;
        n_cmp++; if (starts != 0) begin n_err++; $display("FAIL noint_start: got %0d start cycles want 0", starts); end
        n_cmp++; if (sets != 0) begin n_err++; $display("FAIL idle_done_ignored: got %0d set cycles want 0", sets); end
        interval = 1'b1;
        enable   = 8'h00;
        starts   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_tx_start !== 1'b0) starts++;
        end
        n_cmp++; if (starts != 0) begin n_err++; $display("FAIL disabled_start: got %0d start cycles want 0", starts); end
        enable = 8'h20;
        wait_start(ok, k);
        interval = 1'b0;
        n_cmp++; if (ok !== 1'b1 || k !== 3'd5) begin n_err++; $display("FAIL enable_mask: got ok=%b kind=%0d want ok=1 kind=5", ok, k); end
        tick();
        done = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_cnt_set !== 8'h20) begin n_err++; $display("FAIL enable_set: got %h want 20", o_cnt_set); end
        tick();
        done = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic       ok;
        logic [2:0] k;
        int         sets;
        apply_reset();
        interval = 1'b1;
        elapsed  = 8'h02;
        enable   = 8'hFF;
        ready    = 1'b1;
        wait_start(ok, k);
        interval = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++; if (ok !== 1'b1 || fsm_state !== ST_WAIT_DONE) begin n_err++; $display("FAIL mid_in_wait: got ok=%b state=%0d want ok=1 state=2", ok, fsm_state); end
        rst_n = 1'b0;
        done  = 1'b1;
        #1;
        n_cmp++; if (o_tx_start !== 1'b0 || o_tx_kind !== 3'd0 || o_busy !== 1'b0 || o_timeout !== 1'b0) begin n_err++; $display("FAIL mid_outputs: got start=%b kind=%0d busy=%b to=%b want all 0", o_tx_start, o_tx_kind, o_busy, o_timeout); end
        n_cmp++; if (o_cnt_set !== 8'h00 || o_cnt_interval_set !== 1'b0) begin n_err++; $display("FAIL mid_set: got set=%h int=%b want 00/0", o_cnt_set, o_cnt_interval_set); end
        sets = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_cnt_set !== 8'h00 || o_cnt_interval_set !== 1'b0) sets++;
        end
        n_cmp++; if (sets != 0) begin n_err++; $display("FAIL mid_held_set: got %0d set cycles want 0", sets); end
        done  = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_arbitration();
        test_ready_stall();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_no_interval();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ros2rapper_tx_scheduler.md
ROS2RAPPER_TX_SCHEDULER -- requirements
Module: ros2rapper_tx_scheduler

Interface
REQ-001 SHALL have parameter DONE_TIMEOUT, default 4096, meaning cycles allowed in WAIT_DONE before abort (>=2).
REQ-002 SHALL have port i_clk, input, 1, sole clock.
REQ-003 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_interval_elapsed, input, 1, inter-packet gap counter at zero.
REQ-005 SHALL have port i_kind_elapsed, input, 8, per-kind period counter at zero; index = kind code.
REQ-006 SHALL have port i_kind_enable, input, 8, per-kind transmit enable.
REQ-007 SHALL have port o_cnt_set, output, 8, one-cycle reload pulse per kind counter.
REQ-008 SHALL have port o_cnt_interval_set, output, 1, one-cycle reload pulse for the gap counter.
REQ-009 SHALL have port o_tx_start, output, 1, packet request valid.
REQ-010 SHALL have port o_tx_kind, output, 3, kind code of the request.
REQ-011 SHALL have port i_tx_ready, input, 1, packet generator accepts the request.
REQ-012 SHALL have port i_tx_done, input, 1, one-cycle pulse at packet completion.
REQ-013 SHALL have ports o_busy (output, 1, FSM not IDLE) and o_timeout (output, 1, one-cycle abort pulse).

Function
REQ-014 SHALL use kind codes 0 SPDP_WR, 1 SEDP_PUB_WR, 2 SEDP_SUB_WR, 3 SEDP_PUB_HB, 4 SEDP_SUB_HB, 5 SEDP_PUB_AN, 6 SEDP_SUB_AN, 7 APP_WR.
REQ-015 SHALL form req[k] = i_kind_elapsed[k] & i_kind_enable[k] combinationally.
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT_DONE.
REQ-017 IDLE: when i_interval_elapsed and req!=0, SHALL latch the granted kind into o_tx_kind and go to REQ next cycle; otherwise stay.
REQ-018 REQ: SHALL hold o_tx_start=1 and o_tx_kind stable; on cycle with i_tx_ready=1 SHALL go to WAIT_DONE and clear the timeout counter.
REQ-019 REQ: a request SHALL NOT be withdrawn even if req of the granted kind drops.
REQ-020 WAIT_DONE: timeout counter SHALL increment each cycle; on i_tx_done SHALL pulse o_cnt_set[kind] and o_cnt_interval_set for exactly one cycle and return to IDLE.
REQ-021 WAIT_DONE: if counter reaches DONE_TIMEOUT-1 without i_tx_done, SHALL pulse o_timeout, o_cnt_set[kind] and o_cnt_interval_set one cycle and return to IDLE.
REQ-022 i_tx_done and timeout in the same cycle SHALL be treated as done (no o_timeout).
REQ-023 i_tx_done outside WAIT_DONE SHALL be ignored.
REQ-024 At most one o_cnt_set bit SHALL be high in any cycle; o_tx_start SHALL be high only in REQ.
REQ-025 Timeout counter width SHALL be $clog2(DONE_TIMEOUT) bits, saturating never (cleared before wrap).

Reset
REQ-026 On i_rst_n low SHALL asynchronously force IDLE, o_tx_start=0, o_tx_kind=0, o_cnt_set=0, o_cnt_interval_set=0, o_busy=0, o_timeout=0, timeout counter=0, round-robin pointer=7.
REQ-027 Reset mid-transaction SHALL abort without issuing any set pulse.

Configuration
REQ-028 With ROS2_TX_SCHED_RR_EN defined, arbitration SHALL be round-robin: search starts at pointer+1 (mod 8); pointer updates to granted kind on grant.
REQ-029 Without ROS2_TX_SCHED_RR_EN, arbitration SHALL be fixed priority, lowest index wins; pointer logic absent.

Structure
REQ-030 Kind codes, NUM_KINDS=8 and FSM state encodings SHALL live in a shared package ros2rapper_tx_pkg.
REQ-031 Arbitration SHALL be a sub-module ros2rapper_tx_arbiter (combinational grant + pointer register).

Verification
REQ-032 Reset, interval=1, req=8'h81, ready=1, done 5 cycles later -> kind 0 granted; o_cnt_set=8'h01 and o_cnt_interval_set pulse one cycle.
REQ-033 RR_EN: req=8'h81 held, three transactions -> kinds 0, 7, 0.
REQ-034 No RR_EN: req=8'h81 held, three transactions -> kinds 0, 0, 0.
REQ-035 ready low 10 cycles -> o_tx_start and o_tx_kind stable all 10 cycles, grant on first ready.
REQ-036 DONE_TIMEOUT=16, no done -> o_timeout pulses exactly 16 cycles after accept, set pulses issued, FSM IDLE.
REQ-037 i_interval_elapsed=0 with req=8'hFF -> no o_tx_start; reset asserted in WAIT_DONE -> all outputs 0, no set pulse.
